fetch_sequencer: RTL and testbench

//  Drives the instruction-fetch side of the core: owns the PC register, issues fetch requests to

---
 rtl/fetch_sequencer_if.sv | 30 +++
 rtl/fetch_sequencer.sv | 161 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: next-PC redirect, instruction memory port, decode buffer and status.
// master = the sequencer's view, slave = the surrounding pipeline and memory.
// All sequencer outputs are registered.
interface fetch_sequencer_if;
  logic        start;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [31:0] pc_out;
  logic        fetch_error;
  logic [1:0]  error_cause;

  modport master (
    input  start, stall, redirect_valid, redirect_target, imem_ack, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst_out, inst_pc, pc_out, fetch_error, error_cause
  );

  modport slave (
    output start, stall, redirect_valid, redirect_target, imem_ack, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst_out, inst_pc, pc_out, fetch_error, error_cause
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues imem requests, buffers one instruction for decode.
// Latency: inst_valid one cycle after imem_ack; back-to-back one instruction per two cycles.
// Backpressure: a held buffer (inst_ready=0) or stall blocks the next request; never drops imem_req.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned PC_STEP     = 4,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  fetch_sequencer_if.master bus
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYC - 1);
  localparam logic [1:0]    CAUSE_TMO = 2'b01;
  localparam logic [1:0]    CAUSE_MIS = 2'b10;

  typedef enum logic [2:0] {IDLE, REQ, HOLD, FLUSH, ERROR} state_t;

  state_t        state, state_nxt;
  logic [31:0]   pc, pc_nxt;
  logic [31:0]   addr, addr_nxt;
  logic [31:0]   inst, inst_nxt;
  logic [31:0]   ipc, ipc_nxt;
  logic          vld, vld_nxt;
  logic          err, err_nxt;
  logic [1:0]    cause, cause_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic req, consume, misalign, redir, waiting, timeout;

  assign req      = (state == REQ) || (state == FLUSH);
  assign consume  = vld & bus.inst_ready;
  assign misalign = bus.redirect_valid & (bus.redirect_target[1:0] != 2'b00);
  assign redir    = bus.redirect_valid & ~misalign;
  assign waiting  = req & ~bus.imem_ack;
  // The request has already waited TIMEOUT_CYC-1 cycles; this unacked cycle is the last allowed.
  assign timeout  = waiting && (cnt == TMO_LAST);

  assign bus.imem_req    = req;
  assign bus.imem_addr   = addr;
  assign bus.inst_valid  = vld;
  assign bus.inst_out    = inst;
  assign bus.inst_pc     = ipc;
  assign bus.pc_out      = pc;
  assign bus.fetch_error = err;
  assign bus.error_cause = cause;

  // Next-state and datapath updates; misaligned redirect outranks timeout, errors outrank everything.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    addr_nxt  = addr;
    inst_nxt  = inst;
    ipc_nxt   = ipc;
    vld_nxt   = vld & ~consume;
    err_nxt   = err;
    cause_nxt = cause;
    if (bus.imem_ack) begin
      cnt_nxt = '0;
    end else if (waiting) begin
      cnt_nxt = cnt + CW'(1);
    end else begin
      cnt_nxt = cnt;
    end

    case (state)
      IDLE: begin
        if (misalign) begin
          state_nxt = ERROR;
          cause_nxt = CAUSE_MIS;
        end else if (redir) begin
          pc_nxt = bus.redirect_target;
        end else if (bus.start && !bus.stall) begin
          state_nxt = REQ;
          addr_nxt  = pc;
        end
      end
      REQ: begin
        if (misalign) begin
          state_nxt = ERROR;
          cause_nxt = CAUSE_MIS;
        end else if (timeout) begin
          state_nxt = ERROR;
          cause_nxt = CAUSE_TMO;
        end else if (redir) begin
          // Data returned alongside a redirect is wrong-path; an unacked request must still drain.
          pc_nxt    = bus.redirect_target;
          vld_nxt   = 1'b0;
          state_nxt = bus.imem_ack ? HOLD : FLUSH;
        end else if (bus.imem_ack) begin
          inst_nxt  = bus.imem_rdata;
          ipc_nxt   = addr;
          vld_nxt   = 1'b1;
          pc_nxt    = pc + 32'(PC_STEP);
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (misalign) begin
          state_nxt = ERROR;
          cause_nxt = CAUSE_MIS;
        end else if (redir) begin
          // Squash the buffer; the empty buffer issues to the new PC on a later cycle.
          pc_nxt  = bus.redirect_target;
          vld_nxt = 1'b0;
        end else if ((!vld || consume) && !bus.stall) begin
          state_nxt = REQ;
          addr_nxt  = pc;
        end
      end
      FLUSH: begin
        if (misalign) begin
          state_nxt = ERROR;
          cause_nxt = CAUSE_MIS;
        end else if (timeout) begin
          state_nxt = ERROR;
          cause_nxt = CAUSE_TMO;
        end else begin
          if (redir) pc_nxt = bus.redirect_target;
          if (bus.imem_ack) state_nxt = HOLD;
        end
      end
      default: begin
        state_nxt = ERROR;
      end
    endcase

    if (state_nxt == ERROR) begin
      err_nxt = 1'b1;
      vld_nxt = 1'b0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
      addr  <= RESET_PC;
      inst  <= '0;
      ipc   <= '0;
      vld   <= 1'b0;
      err   <= 1'b0;
      cause <= 2'b00;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      addr  <= addr_nxt;
      inst  <= inst_nxt;
      ipc   <= ipc_nxt;
      vld   <= vld_nxt;
      err   <= err_nxt;
      cause <= cause_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: per-cycle vector table plus timeout and PC-wrap sequences.
// Inputs are driven and registered outputs sampled on the falling edge.
// A second instance with RESET_PC=FFFF_FFFC covers address wrap.
module tb_fetch_sequencer;

  localparam logic [31:0] A = 32'hA000_0000;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  fetch_sequencer_if bus1();
  fetch_sequencer_if bus2();

  fetch_sequencer u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        start;
    logic        stall;
    logic        rv;
    logic [31:0] rt;
    logic        ack;
    logic [31:0] rd;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_out;
    logic [31:0] e_ipc;
    logic [31:0] e_pc;
    logic        e_err;
    logic [1:0]  e_cause;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic rst, input logic start, input logic stall, input logic rv,
                             input logic [31:0] rt, input logic ack, input logic [31:0] rd, input logic rdy,
                             input logic e_req, input logic [31:0] e_addr, input logic e_vld,
                             input logic [31:0] e_out, input logic [31:0] e_ipc, input logic [31:0] e_pc,
                             input logic e_err, input logic [1:0] e_cause);
    vec_t r;
    r.rst = rst; r.start = start; r.stall = stall; r.rv = rv; r.rt = rt; r.ack = ack; r.rd = rd; r.rdy = rdy;
    r.e_req = e_req; r.e_addr = e_addr; r.e_vld = e_vld; r.e_out = e_out; r.e_ipc = e_ipc; r.e_pc = e_pc;
    r.e_err = e_err; r.e_cause = e_cause;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle2();
    bus2.start = 0; bus2.stall = 0; bus2.redirect_valid = 0; bus2.redirect_target = 0;
    bus2.imem_ack = 0; bus2.imem_rdata = 0; bus2.inst_ready = 0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    bus1.start = 0; bus1.stall = 0; bus1.redirect_valid = 0; bus1.redirect_target = 0;
    bus1.imem_ack = 0; bus1.imem_rdata = 0; bus1.inst_ready = 0;
    drive_idle2();

    // rst start stall rv rt ack rd rdy | req addr vld out ipc pc err cause
    // Sequential fetch 0,4,8,C with zero-wait memory.
    vecs.push_back(v(0,1,0,0,0,0,0,1,        0,32'h0,0,0,0,32'h0,0,0));
    vecs.push_back(v(0,0,0,0,0,1,A,1,        1,32'h0,0,0,0,32'h0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,1,        0,32'h0,1,A,32'h0,32'h4,0,0));
    vecs.push_back(v(0,0,0,0,0,1,A|4,1,      1,32'h4,0,A,32'h0,32'h4,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,1,        0,32'h4,1,A|4,32'h4,32'h8,0,0));
    vecs.push_back(v(0,0,0,0,0,1,A|8,1,      1,32'h8,0,A|4,32'h4,32'h8,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,1,        0,32'h8,1,A|8,32'h8,32'hC,0,0));
    vecs.push_back(v(0,0,0,0,0,1,A|32'hC,1,  1,32'hC,0,A|8,32'h8,32'hC,0,0));
    vecs.push_back(v(0,0,1,0,0,0,0,1,        0,32'hC,1,A|32'hC,32'hC,32'h10,0,0));
    vecs.push_back(v(1,0,0,0,0,0,0,0,        0,32'hC,0,A|32'hC,32'hC,32'h10,0,0));
    // Decode backpressure: buffer held five cycles, then fetch resumes at 4.
    vecs.push_back(v(0,1,0,0,0,0,0,0,        0,32'h0,0,0,0,32'h0,0,0));
    vecs.push_back(v(0,0,0,0,0,1,A,0,        1,32'h0,0,0,0,32'h0,0,0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(v(0,0,0,0,0,0,0,0,      0,32'h0,1,A,32'h0,32'h4,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,1,        0,32'h0,1,A,32'h0,32'h4,0,0));
    vecs.push_back(v(0,0,0,0,0,1,A|4,0,      1,32'h4,0,A,32'h0,32'h4,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,1,        0,32'h4,1,A|4,32'h4,32'h8,0,0));
    // Redirect to 0x100 while fetch of 0x8 waits: FLUSH discards 0x8 data.
    vecs.push_back(v(0,0,0,0,0,0,0,1,        1,32'h8,0,A|4,32'h4,32'h8,0,0));
    vecs.push_back(v(0,0,0,1,32'h100,0,0,1,  1,32'h8,0,A|4,32'h4,32'h8,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,1,        1,32'h8,0,A|4,32'h4,32'h100,0,0));
    vecs.push_back(v(0,0,0,0,0,1,A|8,1,      1,32'h8,0,A|4,32'h4,32'h100,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,1,        0,32'h8,0,A|4,32'h4,32'h100,0,0));
    vecs.push_back(v(0,0,0,0,0,1,A|32'h100,1, 1,32'h100,0,A|4,32'h4,32'h100,0,0));
    // Redirect while buffer holds 0x100, then redirect coincident with ack.
    vecs.push_back(v(0,0,0,1,32'h200,0,0,0,  0,32'h100,1,A|32'h100,32'h100,32'h104,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,1,        0,32'h100,0,A|32'h100,32'h100,32'h200,0,0));
    vecs.push_back(v(0,0,0,1,32'h300,1,A|32'h200,1, 1,32'h200,0,A|32'h100,32'h100,32'h200,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,1,        0,32'h200,0,A|32'h100,32'h100,32'h300,0,0));
    vecs.push_back(v(0,0,0,0,0,1,A|32'h300,1, 1,32'h300,0,A|32'h100,32'h100,32'h300,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,1,        0,32'h300,1,A|32'h300,32'h300,32'h304,0,0));
    // Misaligned redirect during a pending fetch: ERROR cause 10, inputs then ignored.
    vecs.push_back(v(0,0,0,1,32'h102,0,0,1,  1,32'h304,0,A|32'h300,32'h300,32'h304,0,0));
    vecs.push_back(v(0,1,0,0,0,1,A,1,        0,32'h304,0,A|32'h300,32'h300,32'h304,1,2'b10));
    vecs.push_back(v(1,0,0,0,0,0,0,1,        0,32'h304,0,A|32'h300,32'h300,32'h304,1,2'b10));
    // Redirect in IDLE, stall blocking start and re-issue, reset mid-fetch.
    vecs.push_back(v(0,0,0,1,32'h40,0,0,0,   0,32'h0,0,0,0,32'h0,0,0));
    vecs.push_back(v(0,1,1,0,0,0,0,0,        0,32'h0,0,0,0,32'h40,0,0));
    vecs.push_back(v(0,1,0,0,0,0,0,0,        0,32'h0,0,0,0,32'h40,0,0));
    vecs.push_back(v(0,0,0,0,0,1,A|32'h40,0, 1,32'h40,0,0,0,32'h40,0,0));
    vecs.push_back(v(0,0,1,0,0,0,0,1,        0,32'h40,1,A|32'h40,32'h40,32'h44,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,1,        0,32'h40,0,A|32'h40,32'h40,32'h44,0,0));
    vecs.push_back(v(1,0,0,0,0,0,0,0,        1,32'h44,0,A|32'h40,32'h40,32'h44,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,0,        0,32'h0,0,0,0,32'h0,0,0));

    @(posedge clk);
    @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      chk($sformatf("row%0d imem_req", i),    32'(bus1.imem_req),    32'(vecs[i].e_req));
      chk($sformatf("row%0d imem_addr", i),   bus1.imem_addr,        vecs[i].e_addr);
      chk($sformatf("row%0d inst_valid", i),  32'(bus1.inst_valid),  32'(vecs[i].e_vld));
      chk($sformatf("row%0d inst_out", i),    bus1.inst_out,         vecs[i].e_out);
      chk($sformatf("row%0d inst_pc", i),     bus1.inst_pc,          vecs[i].e_ipc);
      chk($sformatf("row%0d pc_out", i),      bus1.pc_out,           vecs[i].e_pc);
      chk($sformatf("row%0d fetch_error", i), 32'(bus1.fetch_error), 32'(vecs[i].e_err));
      chk($sformatf("row%0d error_cause", i), 32'(bus1.error_cause), 32'(vecs[i].e_cause));
      reset_n = ~vecs[i].rst;
      bus1.start = vecs[i].start;
      bus1.stall = vecs[i].stall;
      bus1.redirect_valid = vecs[i].rv;
      bus1.redirect_target = vecs[i].rt;
      bus1.imem_ack = vecs[i].ack;
      bus1.imem_rdata = vecs[i].rd;
      bus1.inst_ready = vecs[i].rdy;
    end

    // Ack timeout: error exactly 16 cycles after imem_req rises; stall must not drop the request.
    @(negedge clk);
    reset_n = 1'b0;
    bus1.start = 0; bus1.stall = 0; bus1.redirect_valid = 0; bus1.imem_ack = 0; bus1.inst_ready = 0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    bus1.start = 1;
    @(posedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk($sformatf("tmo%0d imem_req", k),    32'(bus1.imem_req),    32'd1);
      chk($sformatf("tmo%0d fetch_error", k), 32'(bus1.fetch_error), 32'd0);
      bus1.start = 0;
      bus1.stall = 1;
      @(posedge clk);
    end
    @(negedge clk);
    chk("tmo fetch_error", 32'(bus1.fetch_error), 32'd1);
    chk("tmo error_cause", 32'(bus1.error_cause), 32'd1);
    chk("tmo imem_req",    32'(bus1.imem_req),    32'd0);
    bus1.stall = 0;
    bus1.start = 1;
    bus1.imem_ack = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("tmo held imem_req",    32'(bus1.imem_req),    32'd0);
    chk("tmo held fetch_error", 32'(bus1.fetch_error), 32'd1);
    reset_n = 1'b0;
    bus1.start = 0;
    bus1.imem_ack = 0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    chk("tmo clr fetch_error", 32'(bus1.fetch_error), 32'd0);
    chk("tmo clr error_cause", 32'(bus1.error_cause), 32'd0);

    // PC wrap from FFFF_FFFC to 0 on the second instance.
    chk("wrap reset pc_out",    bus2.pc_out,    32'hFFFF_FFFC);
    chk("wrap reset imem_addr", bus2.imem_addr, 32'hFFFF_FFFC);
    bus2.start = 1;
    @(posedge clk);
    @(negedge clk);
    chk("wrap req1",  32'(bus2.imem_req), 32'd1);
    chk("wrap addr1", bus2.imem_addr,     32'hFFFF_FFFC);
    bus2.start = 0;
    bus2.imem_ack = 1;
    bus2.imem_rdata = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    bus2.imem_ack = 0;
    bus2.inst_ready = 1;
    chk("wrap inst_valid", 32'(bus2.inst_valid), 32'd1);
    chk("wrap inst_out",   bus2.inst_out,        32'h1234_5678);
    chk("wrap inst_pc",    bus2.inst_pc,         32'hFFFF_FFFC);
    chk("wrap pc_out",     bus2.pc_out,          32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("wrap req2",  32'(bus2.imem_req), 32'd1);
    chk("wrap addr2", bus2.imem_addr,     32'h0);
    drive_idle2();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
